// File: rtl/seqchk_pkg.sv
// rtl/seqchk_pkg.sv - shared constants, status type and saturating add for seq_resp_checker
package seqchk_pkg;

  localparam int SEQCHK_B_MAX = 3;
  localparam int SEQCHK_J_LEN = 4;
  localparam int SEQCHK_CNT_W = 8;

  typedef struct packed {
    logic pass;
    logic fail;
    logic active;
  } seqchk_status_t;

  // Adds inc to cnt and clamps at cnt_max; 33-bit sum so no carry is lost.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic [31:0] inc,
                                          input logic [31:0] cnt_max);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    if (sum > {1'b0, cnt_max}) begin
      return cnt_max;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/seqchk_en_detect.sv
// rtl/seqchk_en_detect.sv - enabling-sequence detector for C ##1 B[*1:B_MAX] ##1 A
module seqchk_en_detect
  import seqchk_pkg::*;
#(
  parameter int B_MAX = SEQCHK_B_MAX
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic x_i,
  output logic en_match_o,
  output logic prefix_active_o
);

  // s_q[k]: a C was seen k+1 cycles ago, followed by k consecutive B cycles.
  logic [B_MAX:0] s_q;
  logic [B_MAX:0] s_d;

  // Advance every prefix in parallel; X wipes all of them, including a C seen this cycle.
  always_comb begin
    s_d    = '0;
    s_d[0] = c_i;
    for (int k = 1; k <= B_MAX; k++) begin
      s_d[k] = s_q[k-1] & b_i;
    end
    if (x_i) begin
      s_d = '0;
    end
  end

  // Prefix vector register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  // Any live prefix with at least one B closes on A; several lengths collapse into one match.
  assign en_match_o      = a_i & ~x_i & (|s_q[B_MAX:1]);
  assign prefix_active_o = |s_q;

endmodule

// File: rtl/seq_resp_checker.sv
// rtl/seq_resp_checker.sv - hardware scoreboard: enable C ##1 B[*1:B_MAX] ##1 A, then J[*J_LEN] ##1 K; optional SEQCHK_ABORT_CNT_EN adds abort_cnt_o
module seq_resp_checker
  import seqchk_pkg::*;
#(
  parameter int B_MAX = SEQCHK_B_MAX,
  parameter int J_LEN = SEQCHK_J_LEN,
  parameter int CNT_W = SEQCHK_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             c_i,
  input  logic             j_i,
  input  logic             k_i,
  input  logic             x_i,
  output logic             pass_o,
  output logic             fail_o,
  output logic             active_o,
  output logic [CNT_W-1:0] fail_cnt_o
`ifdef SEQCHK_ABORT_CNT_EN
  ,
  output logic [CNT_W-1:0] abort_cnt_o
`endif
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic             en_match;
  logic             prefix_active;

  // pend_q[i]: an obligation that has already seen i J cycles since its enable.
  logic [J_LEN:0]   pend_q;
  logic [J_LEN:0]   pend_d;
  logic [J_LEN:0]   fail_vec;
  logic [31:0]      n_fail;
  logic             pass_q;
  logic             pass_d;
  logic             fail_q;
  logic             fail_d;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [CNT_W-1:0] fail_cnt_d;
  seqchk_status_t   status;

  seqchk_en_detect #(
    .B_MAX(B_MAX)
  ) u_en_detect (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .c_i            (c_i),
    .x_i            (x_i),
    .en_match_o     (en_match),
    .prefix_active_o(prefix_active)
  );

  // Evaluate every in-flight obligation against this cycle's J/K and shift the survivors.
  always_comb begin
    fail_vec = '0;
    for (int i = 0; i < J_LEN; i++) begin
      fail_vec[i] = pend_q[i] & ~j_i;
    end
    fail_vec[J_LEN] = pend_q[J_LEN] & ~k_i;

    pend_d    = '0;
    pend_d[0] = en_match;
    for (int i = 1; i <= J_LEN; i++) begin
      pend_d[i] = pend_q[i-1] & j_i;
    end

    n_fail     = 32'($countones(fail_vec));
    pass_d     = pend_q[J_LEN] & k_i;
    fail_d     = |fail_vec;
    fail_cnt_d = CNT_W'(sat_add(32'(fail_cnt_q), n_fail, CNT_MAX));

    // An abort discards this cycle's verdicts and leaves the fail count alone.
    if (x_i) begin
      pend_d     = '0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      fail_cnt_d = fail_cnt_q;
    end
  end

  // Obligation pipe, verdict pulses and fail counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q     <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

`ifdef SEQCHK_ABORT_CNT_EN
  logic [CNT_W-1:0] abort_cnt_q;
  logic [CNT_W-1:0] abort_cnt_d;

  // Count aborts that actually threw away a pending obligation.
  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (x_i && (|pend_q)) begin
      abort_cnt_d = CNT_W'(sat_add(32'(abort_cnt_q), 32'd1, CNT_MAX));
    end
  end

  // Abort counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      abort_cnt_q <= '0;
    end else begin
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign abort_cnt_o = abort_cnt_q;
`endif

  // Collect the visible status; active depends on registers only.
  always_comb begin
    status        = '0;
    status.pass   = pass_q;
    status.fail   = fail_q;
    status.active = prefix_active | (|pend_q);
  end

  assign pass_o     = status.pass;
  assign fail_o     = status.fail;
  assign active_o   = status.active;
  assign fail_cnt_o = fail_cnt_q;

endmodule

// File: tb/tb_seq_resp_checker.sv
// tb/tb_seq_resp_checker.sv - directed table-driven bench for seq_resp_checker
module tb_seq_resp_checker;

  logic       clk;
  logic       rst_n;
  logic       a, b, c, j, k, x;
  logic       pass_w, fail_w, active_w;
  logic [7:0] fail_cnt_w;
`ifdef SEQCHK_ABORT_CNT_EN
  logic [7:0] abort_cnt_w;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [5:0] in_cbajkx;
    logic [2:0] exp_pfa;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  seq_resp_checker #(
    .B_MAX(3),
    .J_LEN(4),
    .CNT_W(8)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .a_i       (a),
    .b_i       (b),
    .c_i       (c),
    .j_i       (j),
    .k_i       (k),
    .x_i       (x),
    .pass_o    (pass_w),
    .fail_o    (fail_w),
    .active_o  (active_w),
    .fail_cnt_o(fail_cnt_w)
`ifdef SEQCHK_ABORT_CNT_EN
    ,
    .abort_cnt_o(abort_cnt_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic step(input logic [5:0] cbajkx);
    @(negedge clk);
    {c, b, a, j, k, x} = cbajkx;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] in_v, input logic [2:0] pfa, input logic [7:0] cnt);
    vec_t v;
    v.in_cbajkx = in_v;
    v.exp_pfa   = pfa;
    v.exp_cnt   = cnt;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [5:0] in_v, input logic [2:0] pfa,
                       input logic [7:0] cnt);
    for (int i = 0; i < n; i++) add(in_v, pfa, cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    {c, b, a, j, k, x} = '0;

    // normal pass: C;B;A;J*4;K
    add(6'b100000, 3'b001, 0); add(6'b010000, 3'b001, 0); add(6'b001000, 3'b001, 0);
    add_n(4, 6'b000100, 3'b001, 0);
    add(6'b000010, 3'b100, 0); add(6'b000000, 3'b000, 0);
    // maximum B repeat
    add(6'b100000, 3'b001, 0); add_n(3, 6'b010000, 3'b001, 0); add(6'b001000, 3'b001, 0);
    add_n(4, 6'b000100, 3'b001, 0);
    add(6'b000010, 3'b100, 0); add(6'b000000, 3'b000, 0);
    // four B: no match, active drops after the fourth B
    add(6'b100000, 3'b001, 0); add_n(3, 6'b010000, 3'b001, 0);
    add(6'b010000, 3'b000, 0); add(6'b001000, 3'b000, 0); add(6'b000000, 3'b000, 0);
    // short J
    add(6'b100000, 3'b001, 0); add(6'b010000, 3'b001, 0); add(6'b001000, 3'b001, 0);
    add_n(3, 6'b000100, 3'b001, 0);
    add(6'b000000, 3'b010, 1); add(6'b000010, 3'b000, 1); add(6'b000000, 3'b000, 1);
    // overlap: C;B;A;J;J;CJ;JB;KA;J;J;J;J;K
    add(6'b100000, 3'b001, 1); add(6'b010000, 3'b001, 1); add(6'b001000, 3'b001, 1);
    add_n(2, 6'b000100, 3'b001, 1);
    add(6'b100100, 3'b001, 1); add(6'b010100, 3'b001, 1); add(6'b001010, 3'b101, 1);
    add_n(4, 6'b000100, 3'b001, 1);
    add(6'b000010, 3'b100, 1); add(6'b000000, 3'b000, 1);
    // abort: C;B;A;J;J;X;J;J;K
    add(6'b100000, 3'b001, 1); add(6'b010000, 3'b001, 1); add(6'b001000, 3'b001, 1);
    add_n(2, 6'b000100, 3'b001, 1);
    add(6'b000001, 3'b000, 1); add_n(2, 6'b000100, 3'b000, 1);
    add(6'b000010, 3'b000, 1); add(6'b000000, 3'b000, 1);
    // X in the A cycle suppresses the match
    add(6'b100000, 3'b001, 1); add(6'b010000, 3'b001, 1);
    add(6'b001001, 3'b000, 1); add(6'b000000, 3'b000, 1);
    // two obligations failing in one cycle
    add(6'b100000, 3'b001, 1); add(6'b110000, 3'b001, 1); add(6'b011000, 3'b001, 1);
    add(6'b001100, 3'b001, 1); add(6'b000000, 3'b010, 3); add(6'b000000, 3'b000, 3);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset pass", pass_w, 0);
    check("reset fail", fail_w, 0);
    check("reset active", active_w, 0);
    check("reset fail_cnt", fail_cnt_w, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].in_cbajkx);
      check($sformatf("row%0d pass", i), pass_w, vecs[i].exp_pfa[2]);
      check($sformatf("row%0d fail", i), fail_w, vecs[i].exp_pfa[1]);
      check($sformatf("row%0d active", i), active_w, vecs[i].exp_pfa[0]);
      check($sformatf("row%0d fail_cnt", i), fail_cnt_w, vecs[i].exp_cnt);
    end
`ifdef SEQCHK_ABORT_CNT_EN
    check("abort_cnt", abort_cnt_w, 1);
`endif

    // reset mid-check during J;J
    step(6'b100000); step(6'b010000); step(6'b001000); step(6'b000100);
    step(6'b000100);
    rst_n = 1'b0;
    #1;
    check("async rst pass", pass_w, 0);
    check("async rst fail", fail_w, 0);
    check("async rst active", active_w, 0);
    check("async rst fail_cnt", fail_cnt_w, 0);
`ifdef SEQCHK_ABORT_CNT_EN
    check("async rst abort_cnt", abort_cnt_w, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) if (i < 3) begin
      step(i == 2 ? 6'b000010 : 6'b000100);
      check($sformatf("post rst %0d pass", i), pass_w, 0);
      check($sformatf("post rst %0d fail", i), fail_w, 0);
      check($sformatf("post rst %0d active", i), active_w, 0);
    end

    // saturation: A,B,C held with J low fails one obligation per cycle from the fourth edge
    repeat (10) step(6'b111000);
    check("sat ramp fail_cnt", fail_cnt_w, 7);
    check("sat ramp fail", fail_w, 1);
    repeat (290) step(6'b111000);
    check("sat fail_cnt", fail_cnt_w, 255);
    step(6'b000000);
    check("sat drain fail_cnt", fail_cnt_w, 255);
    check("sat drain active", active_w, 0);
    step(6'b100000); step(6'b010000); step(6'b001000); step(6'b000000);
    check("sat extra fail", fail_w, 1);
    check("sat extra fail_cnt", fail_cnt_w, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seq_resp_checker.md
Name: seq_resp_checker

Overview:
- Synthesizable RTL responder for the A/B/C/J/K/X handshake stimulus used by the sequence-training bench.
- Recognises the enabling sequence C ##1 B[*1:B_MAX] ##1 A, then enforces the fulfilling sequence J[*J_LEN] ##1 K starting the cycle after the enable match.
- Reports pass/fail pulses and a saturating fail count. X aborts all activity.
- Sits beside the stimulus driver as a hardware scoreboard, so gate-level and emulation runs can check the protocol without SVA.

Parameters:
- B_MAX, 3, maximum B repetitions in the enabling sequence (≥1)
- J_LEN, 4, required consecutive J cycles before K (≥1)
- CNT_W, 8, width of FAIL_CNT

Ports:
- CLK  in  1  clock, all state on posedge
- RST_N  in  1  asynchronous active-low reset
- A, B, C  in  1 each  enabling-sequence inputs
- J, K  in  1 each  fulfilling-sequence inputs
- X  in  1  disable/abort
- PASS  out  1  one-cycle pulse: an obligation completed
- FAIL  out  1  one-cycle pulse: at least one obligation failed
- ACTIVE  out  1  high while any enabling prefix or obligation is pending
- FAIL_CNT  out  CNT_W  saturating count of failed obligations

Behaviour:
- Reset, asserted asynchronously: all state cleared. PASS=0, FAIL=0, ACTIVE=0, FAIL_CNT=0.
- Enable detector:
  - EN_MATCH(t) = A(t) & C(t-k-1) & B(t-k..t-1) for some k in 1..B_MAX.
  - Implement as prefix vector s[0..B_MAX]. s[0] <= C. s[k] <= s[k-1] & B.
  - Multiple k matching in the same cycle collapse to one match.
  - A, B and C may all be high in one cycle, which starts new prefixes while continuing old ones.
- Obligation pipe:
  - pend[0..J_LEN] shift register. pend[0] <= EN_MATCH. pend[i] <= pend[i-1] & J for i ≥ 1.
  - pend[i], i < J_LEN: requires J in the current cycle. If J=0, that obligation fails and is dropped.
  - pend[J_LEN]: requires K. K=1 means pass, K=0 means fail. The obligation retires either way.
  - Overlapping obligations are independent. Up to J_LEN+1 may be in flight.
  - Overlapped enables share input values, so several obligations failing in one cycle is legal.
- Outputs are registered:
  - PASS/FAIL are asserted in cycle t+1 for an evaluation in cycle t.
  - PASS and FAIL may both be high in the same cycle (different obligations).
  - FAIL_CNT adds popcount(failing obligations) and saturates at 2^CNT_W-1.
- ACTIVE = |s[0..B_MAX] | |pend. Combinational from registers; no input path.
- Disable: X=1 in cycle t clears s and pend at the next edge.
  - No PASS/FAIL is produced from cycle t evaluations.
  - EN_MATCH in cycle t is suppressed.
  - FAIL_CNT is unchanged.
- State machine view, for verification: IDLE (ACTIVE=0), ARMING (prefix only), CHECKING (pend≠0). Transitions are derived from the vectors, with no extra encoded state.
- Latency: one enable match at t leads to PASS at t+J_LEN+2.

Optional Feature:
- Macro SEQCHK_ABORT_CNT_EN.
- Defined:
  - Adds output ABORT_CNT [CNT_W-1:0].
  - Increments, saturating, on each X cycle where pend≠0 before clearing.
  - Reset value 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- seqchk_pkg:
  - Default constants SEQCHK_B_MAX=3, SEQCHK_J_LEN=4, SEQCHK_CNT_W=8.
  - typedef seqchk_status_t, a struct of {pass, fail, active}.
  - Saturating-add function sat_add(cnt, inc).
- Sub-module seqchk_en_detect:
  - Owns s[], takes A/B/C/X, outputs EN_MATCH and prefix_active.
  - seq_resp_checker instantiates it and owns pend, counters and outputs.

Test Plan:
- Normal pass: cycles C;B;A;J;J;J;J;K. PASS pulses once, 1 cycle after K. FAIL=0, FAIL_CNT=0.
- Maximum B repeat: C;B;B;B;A;J;J;J;J;K. PASS once. C;B;B;B;B;A gives no match and ACTIVE drops after the fourth B.
- Short J: C;B;A;J;J;J;;K. FAIL pulses 1 cycle after the empty cycle. FAIL_CNT=1. No PASS.
- Overlap:
  - Stimulus: C;B;A;J;J;CJ;JB;KA;J;J;J;J;K.
  - First obligation passes at the KA cycle +1.
  - Second enable (C,B,A) yields PASS after its own J[*4]##1K. FAIL_CNT=0.
- Abort: C;B;A;J;J;X;J;J;K. No PASS/FAIL, ACTIVE=0 after the X edge. With SEQCHK_ABORT_CNT_EN, ABORT_CNT=1.
- Reset mid-check:
  - Stimulus: deassert RST_N for half a cycle during J;J.
  - All outputs 0 immediately. Following J;J;K produces nothing.
  - FAIL_CNT saturation: force 255 fails with CNT_W=8, then one more fail. FAIL_CNT stays 255.
